// File: rtl/audio_sd_dac_mc.sv
// Multi-channel first-order sigma-delta audio DAC with per-channel click-free mute ramps.
// Latency strobe->dac_o 3 clocks in PLAY; no backpressure, every strobe is accepted.
module audio_sd_dac_mc #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 2,
  parameter int RAMP_DIV = 64
) (
  input  logic                      clk_i,
  input  logic                      res_n_i,
  input  logic [CHANNELS*WIDTH-1:0] dac_i,
  input  logic                      sample_stb_i,
  input  logic                      signed_i,
  input  logic [CHANNELS-1:0]       mute_i,
  output logic [CHANNELS-1:0]       dac_o,
  output logic [CHANNELS-1:0]       busy_o
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0]    PS_LAST = PW'(RAMP_DIV - 1);
  localparam logic [WIDTH-1:0] MID     = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {PLAY, MUTING, MUTED, UNMUTING} state_t;

  // One LSB toward the target; saturates at the target so it can never overshoot or wrap.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    if (cur < tgt)
      return cur + 1'b1;
    else if (cur > tgt)
      return cur - 1'b1;
    else
      return cur;
  endfunction

  logic [PW-1:0] ps_cnt;
  logic          tick;

  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk_i) begin
    if (!res_n_i)
      ps_cnt <= '0;
    else
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] samp_in;
    logic [WIDTH-1:0] eff;
    logic [WIDTH-1:0] eff_nxt;
    logic [WIDTH:0]   acc;
    logic             busy;

    // Two's complement becomes offset binary by flipping the sign bit.
    assign samp_in = dac_i[n*WIDTH +: WIDTH] ^ {signed_i, {(WIDTH-1){1'b0}}};

    always_comb begin
      state_nxt = state;
      eff_nxt   = eff;
      case (state)
        PLAY: begin
          eff_nxt = samp;
          if (mute_i[n])
            state_nxt = MUTING;
        end
        MUTING: begin
          if (tick)
            eff_nxt = step_toward(eff, MID);
          if (!mute_i[n])
            state_nxt = UNMUTING;
          else if (eff == MID)
            state_nxt = MUTED;
        end
        MUTED: begin
          eff_nxt = MID;
          if (!mute_i[n])
            state_nxt = UNMUTING;
        end
        UNMUTING: begin
          // Tracks the live sample so a new strobe retargets the ramp instead of jumping.
          if (tick)
            eff_nxt = step_toward(eff, samp);
          if (mute_i[n])
            state_nxt = MUTING;
          else if (eff == samp)
            state_nxt = PLAY;
        end
        default: state_nxt = PLAY;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (!res_n_i) begin
        samp  <= MID;
        eff   <= MID;
        acc   <= '0;
        state <= mute_i[n] ? MUTED : PLAY;
        busy  <= 1'b0;
      end else begin
        if (sample_stb_i)
          samp <= samp_in;
        eff   <= eff_nxt;
        acc   <= {1'b0, acc[WIDTH-1:0]} + {1'b0, eff};
        state <= state_nxt;
        busy  <= (state_nxt == MUTING) || (state_nxt == UNMUTING);
      end
    end

    assign dac_o[n]  = acc[WIDTH];
    assign busy_o[n] = busy;
  end

endmodule

// File: doc/audio_sd_dac_mc.md
AUDIO_SD_DAC_MC -- requirements
Module: audio_sd_dac_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 9: sample width in bits per channel, minimum 4.
REQ-002 SHALL have parameter CHANNELS, default 2: number of independent DAC channels, minimum 1.
REQ-003 SHALL have parameter RAMP_DIV, default 64: clocks per mute-ramp step, minimum 1.
REQ-004 SHALL have port clk_i, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port res_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port dac_i, input, CHANNELS*WIDTH bits: channel n sample at bits [n*WIDTH +: WIDTH].
REQ-007 SHALL have port sample_stb_i, input, 1 bit: when high, all channels latch dac_i.
REQ-008 SHALL have port signed_i, input, 1 bit: 1 means dac_i is two's complement, 0 means offset binary.
REQ-009 SHALL have port mute_i, input, CHANNELS bits: per-channel mute request, level-sensitive.
REQ-010 SHALL have port dac_o, output, CHANNELS bits: per-channel 1-bit sigma-delta stream.
REQ-011 SHALL have port busy_o, output, CHANNELS bits: per-channel flag, high while a mute or unmute ramp is in progress.

Function
REQ-012 SHALL latch samp[n] (unsigned, WIDTH bits) from dac_i in the cycle sample_stb_i=1; when signed_i=1 the MSB SHALL be inverted before latching; otherwise samp[n] SHALL hold its value.
REQ-013 SHALL define MID = 2^(WIDTH-1).
REQ-014 SHALL keep one shared prescaler counting 0..RAMP_DIV-1 and wrapping; tick = 1 in the cycle the count equals RAMP_DIV-1.
REQ-015 SHALL give each channel a state machine with states PLAY, MUTING, MUTED and UNMUTING, plus an effective-value register eff[n].
REQ-016 PLAY: eff <= samp each cycle; mute_i[n]=1 -> MUTING.
REQ-017 MUTING: on tick, eff SHALL step 1 LSB toward MID; eff==MID -> MUTED, evaluated before the step; mute_i[n]=0 -> UNMUTING, with mute taking priority over arrival at MID.
REQ-018 MUTED: eff SHALL hold at MID; mute_i[n]=0 -> UNMUTING.
REQ-019 UNMUTING: on tick, eff SHALL step 1 LSB toward the current samp[n]; eff==samp[n] -> PLAY; mute_i[n]=1 -> MUTING, with priority.
REQ-020 If samp changes during UNMUTING, SHALL retarget to the new samp and SHALL NOT jump to it.
REQ-021 Step arithmetic SHALL never overshoot the target and SHALL NOT wrap below 0 or above 2^WIDTH-1.
REQ-022 busy_o[n] SHALL be 1 exactly when state is MUTING or UNMUTING (registered state decode).
REQ-023 Modulator per channel SHALL be first-order: acc is WIDTH+1 bits; each cycle acc <= {0, acc[WIDTH-1:0]} + eff; dac_o[n] = acc[WIDTH] (registered).
REQ-024 Pulse density of dac_o[n] over 2^WIDTH cycles SHALL equal eff/2^WIDTH exactly for constant eff.
REQ-025 Latency in PLAY: strobe at edge k -> samp at k+1 -> eff at k+2 -> first affected dac_o at k+3.
REQ-026 Channels SHALL be fully independent except for the shared prescaler and the shared sample_stb_i/signed_i.

Reset
REQ-027 While res_n_i=0 at a clock edge: samp=MID, eff=MID, acc=0, prescaler=0, state=MUTED if mute_i[n]=1 else PLAY, dac_o=0, busy_o=0.
REQ-028 Reset mid-ramp SHALL abandon the ramp; no ramp SHALL resume after release.
REQ-029 First strobe after release SHALL be honoured normally; no minimum idle time after reset.

Verification (WIDTH=9, CHANNELS=2, RAMP_DIV=4)
REQ-030 Reset, no strobe -> both dac_o patterns alternate 0/1 after the first cycle (density 256/512), busy_o=00.
REQ-031 Strobe ch0=0, ch1=511, signed_i=0 -> from k+3 dac_o[0] constant 0, dac_o[1] density 511/512 over 512 cycles.
REQ-032 signed_i=1, strobe ch0=9'h000, ch1=9'h1FF (-1) -> samp0=256, samp1=255, checked via density over 512 cycles.
REQ-033 ch0 samp=300 in PLAY, assert mute_i[0] -> busy_o[0]=1, eff0 decrements once per 4 clocks, reaches 256 after 44 ticks, then MUTED with busy_o[0]=0; ch1 unaffected.
REQ-034 In MUTED, deassert mute and strobe 260 two ticks later -> eff rises 256,257,...,260 one per tick, PLAY entered on equality, no overshoot; re-assert mute mid-ramp -> immediate reversal toward 256.
REQ-035 res_n_i=0 for one cycle during MUTING at eff=280 -> next cycle eff=256, acc=0, busy_o=0, state PLAY if mute_i=0.
